// File: rtl/membrane_integrator.sv
// Leaky integrate-and-fire membrane integrator with saturating accumulation and a refractory window.
// Optional macro MEMBRANE_LEAK_EN enables the per-cycle arithmetic-shift leak; undefined gives a pure integrator.
module membrane_integrator #(
    parameter int WIDTH          = 16,
    parameter int LEAK_SHIFT     = 4,
    parameter int REFRACT_CYCLES = 3,
    parameter int V_RESET        = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_weight,
    output logic                    in_ready,
    input  logic                    spike_in,
    output logic signed [WIDTH-1:0] membrane_potential,
    output logic                    refractory,
    output logic [15:0]             spike_count
);

    localparam int SW = WIDTH + 2;

    localparam logic signed [WIDTH-1:0] V_RST        = WIDTH'(V_RESET);
    localparam logic [7:0]              REFRACT_LOAD = 8'(REFRACT_CYCLES);

    localparam logic signed [SW-1:0]    SAT_MAX_EXT  = {3'b000, {(WIDTH-1){1'b1}}};
    localparam logic signed [SW-1:0]    SAT_MIN_EXT  = {3'b111, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] SAT_MAX      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0] SAT_MIN      = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } state_t;

    state_t                  state;
    logic [7:0]              refr_cnt;
    logic                    accept;
    logic signed [WIDTH-1:0] leak;
    logic signed [SW-1:0]    v_ext;
    logic signed [SW-1:0]    leak_ext;
    logic signed [SW-1:0]    w_ext;
    logic signed [SW-1:0]    sum;
    logic signed [WIDTH-1:0] next_v;

    assign in_ready = (state == INTEGRATE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        leak   = '0;
`ifdef MEMBRANE_LEAK_EN
        // Arithmetic shift makes negative potentials decay toward zero as well.
        leak   = membrane_potential >>> LEAK_SHIFT;
`endif
        v_ext    = {{2{membrane_potential[WIDTH-1]}}, membrane_potential};
        leak_ext = {{2{leak[WIDTH-1]}}, leak};
        w_ext    = accept ? {{2{in_weight[WIDTH-1]}}, in_weight} : '0;
        sum      = v_ext - leak_ext + w_ext;

        if (sum > SAT_MAX_EXT) begin
            next_v = SAT_MAX;
        end else if (sum < SAT_MIN_EXT) begin
            next_v = SAT_MIN;
        end else begin
            next_v = sum[WIDTH-1:0];
        end
    end

    // NOTE: all state below is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            membrane_potential <= V_RST;
            state              <= INTEGRATE;
            refractory         <= 1'b0;
            refr_cnt           <= '0;
            spike_count        <= '0;
        end else begin
            case (state)
                INTEGRATE: begin
                    if (spike_in) begin
                        // A spike wins over any event accepted in the same cycle.
                        membrane_potential <= V_RST;
                        spike_count        <= spike_count + 16'd1;
                        if (REFRACT_CYCLES != 0) begin
                            state      <= REFRACTORY;
                            refractory <= 1'b1;
                            refr_cnt   <= REFRACT_LOAD;
                        end
                    end else begin
                        membrane_potential <= next_v;
                    end
                end
                REFRACTORY: begin
                    membrane_potential <= V_RST;
                    refr_cnt           <= refr_cnt - 8'd1;
                    if (refr_cnt == 8'd1) begin
                        state      <= INTEGRATE;
                        refractory <= 1'b0;
                    end
                end
                default: begin
                    state      <= INTEGRATE;
                    refractory <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membrane_integrator.sv
// Scoreboard bench: stimulus pushes reference-model expectations, monitors compare after each clock edge.
// A second instance with REFRACT_CYCLES=0 exercises spike_count wrap-around.
module tb_membrane_integrator;

    localparam int W      = 16;
    localparam int LSHIFT = 4;
    localparam int NREF   = 3;
    localparam int VRST   = 0;
    localparam int VMAX   = 32767;
    localparam int VMIN   = -32768;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance
    logic                rst = 1'b1;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_weight = '0;
    logic                spike_in = 1'b0;
    logic                in_ready;
    logic signed [W-1:0] membrane_potential;
    logic                refractory;
    logic [15:0]         spike_count;

    // zero-refractory instance
    logic                rst0 = 1'b1;
    logic                valid0 = 1'b0;
    logic signed [W-1:0] weight0 = '0;
    logic                spike0 = 1'b0;
    logic                ready0;
    logic signed [W-1:0] mp0;
    logic                refr0;
    logic [15:0]         cnt0;

    membrane_integrator #(.WIDTH(W), .LEAK_SHIFT(LSHIFT), .REFRACT_CYCLES(NREF), .V_RESET(VRST)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_weight(in_weight), .in_ready(in_ready),
        .spike_in(spike_in), .membrane_potential(membrane_potential), .refractory(refractory),
        .spike_count(spike_count)
    );

    membrane_integrator #(.WIDTH(W), .LEAK_SHIFT(LSHIFT), .REFRACT_CYCLES(0), .V_RESET(VRST)) dut0 (
        .clk(clk), .rst(rst0), .in_valid(valid0), .in_weight(weight0), .in_ready(ready0),
        .spike_in(spike0), .membrane_potential(mp0), .refractory(refr0), .spike_count(cnt0)
    );

    typedef struct {
        int v;
        bit refr;
        bit ready;
        int count;
        string tag;
    } exp_t;

    exp_t q[$];
    exp_t q0[$];

    int checks = 0;
    int errors = 0;

    // reference model state: potential, refractory flag, remaining blocked cycles, spike total
    int m_v = VRST;
    bit m_refr = 1'b0;
    int m_rem = 0;
    int m_count = 0;
    int m0_count = 0;

    task automatic check(input string name, input int actual, input int expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic int leak_of(input int v);
`ifdef MEMBRANE_LEAK_EN
        return v >>> LSHIFT;
`else
        return 0;
`endif
    endfunction

    task automatic drive(input bit r, input bit val, input int w, input bit sp, input string tag);
        exp_t e;
        int s;
        @(negedge clk);
        rst = r;
        in_valid = val;
        in_weight = W'(w);
        spike_in = sp;
        if (r) begin
            m_v = VRST; m_refr = 1'b0; m_rem = 0; m_count = 0;
        end else if (m_refr) begin
            m_v = VRST;
            m_rem--;
            if (m_rem == 0) m_refr = 1'b0;
        end else if (sp) begin
            m_v = VRST;
            m_count = (m_count + 1) % 65536;
            if (NREF > 0) begin m_refr = 1'b1; m_rem = NREF; end
        end else begin
            s = m_v - leak_of(m_v) + (val ? w : 0);
            m_v = (s > VMAX) ? VMAX : (s < VMIN) ? VMIN : s;
        end
        e.v = m_v; e.refr = m_refr; e.ready = !m_refr; e.count = m_count; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic drive0(input bit r, input bit val, input int w, input bit sp);
        exp_t e;
        @(negedge clk);
        rst0 = r;
        valid0 = val;
        weight0 = W'(w);
        spike0 = sp;
        if (r) m0_count = 0;
        else if (sp) m0_count = (m0_count + 1) % 65536;
        e.v = VRST; e.refr = 1'b0; e.ready = 1'b1; e.count = m0_count; e.tag = "wrap";
        q0.push_back(e);
    endtask

    // monitors: sample 1 time unit after the rising edge
    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            e = q.pop_front();
            check({e.tag, ".v"}, int'(membrane_potential), e.v);
            check({e.tag, ".refractory"}, int'(refractory), int'(e.refr));
            check({e.tag, ".in_ready"}, int'(in_ready), int'(e.ready));
            check({e.tag, ".spike_count"}, int'(spike_count), e.count);
        end
    end

    initial forever begin
        exp_t e;
        @(posedge clk);
        #1;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("wrap.v", int'(mp0), e.v);
            check("wrap.refractory", int'(refr0), int'(e.refr));
            check("wrap.in_ready", int'(ready0), int'(e.ready));
            check("wrap.spike_count", int'(cnt0), e.count);
        end
    end

    initial begin
        int w;
        int bound;

        // reset then three events of weight 5
        drive(1, 0, 0, 0, "reset");
        drive(1, 1, 9, 1, "reset_spike");
        for (int i = 0; i < 3; i++) drive(0, 1, 5, 0, "accum5");
        drive(0, 0, 0, 0, "idle");

        // positive and negative saturation
        drive(1, 0, 0, 0, "reset");
        drive(0, 1, 16000, 0, "sat_up");
        drive(0, 1, 16000, 0, "sat_up");
        drive(0, 1, 760, 0, "sat_up");
        drive(0, 1, 100, 0, "sat_max");
        drive(0, 1, 30000, 0, "sat_hold");
        drive(1, 0, 0, 0, "reset");
        drive(0, 1, -16000, 0, "sat_dn");
        drive(0, 1, -16000, 0, "sat_dn");
        drive(0, 1, -760, 0, "sat_dn");
        drive(0, 1, -100, 0, "sat_min");

        // leak check from 160 and from -5 (leak-free build just holds)
        drive(1, 0, 0, 0, "reset");
        drive(0, 1, 160, 0, "leak_load");
        drive(0, 0, 0, 0, "leak1");
        drive(0, 0, 0, 0, "leak2");
        drive(1, 0, 0, 0, "reset");
        drive(0, 1, -5, 0, "leak_neg_load");
        drive(0, 0, 0, 0, "leak_neg");

        // spike with a simultaneous event, spikes ignored during refractory
        drive(1, 0, 0, 0, "reset");
        drive(0, 1, 200, 0, "pre_spike");
        drive(0, 1, 7, 1, "spike");
        drive(0, 1, 7, 1, "refr1");
        drive(0, 1, 7, 1, "refr2");
        drive(0, 1, 7, 1, "refr3");
        drive(0, 1, 7, 0, "post_refr");

        // reset in the 2nd refractory cycle
        drive(0, 0, 0, 1, "spike2");
        drive(0, 1, 3, 0, "refr_a");
        drive(1, 0, 0, 1, "rst_in_refr");
        drive(0, 1, 4, 0, "after_rst");

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 1) == 0) w = int'($urandom_range(0, 600)) - 300;
            else w = int'($urandom_range(0, 65535)) - 32768;
            drive($urandom_range(0, 99) == 0, $urandom_range(0, 2) != 0, w,
                  $urandom_range(0, 19) == 0, "random");
        end
        drive(0, 0, 0, 0, "idle");

        // zero-refractory instance: 65536 back-to-back spikes
        drive0(1, 0, 0, 0);
        for (int i = 0; i < 65536; i++) begin
            drive0(0, $urandom_range(0, 1), int'($urandom_range(0, 65535)) - 32768, 1);
        end
        drive0(0, 0, 0, 0);

        bound = 0;
        while ((q.size() > 0 || q0.size() > 0) && bound < 20) begin
            @(posedge clk);
            bound++;
        end
        #2;
        if (q.size() > 0 || q0.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", q.size() + q0.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
